// File: rtl/ct_l2c_data_pkg.sv
// ---------------------------------------------------------------------------
// ct_l2c_data_pkg
// Shared definitions for the L2 data-array SRAM access controller:
//   ADDR_W / DATA_W / BE_W : SRAM index, data and byte-enable widths
//   LAT                    : read-valid tracking pipeline length
//   be_to_mask()           : byte enables -> per-bit mask
// Build option: CT_L2C_DATA_RD_FLOP_EN adds a capture flop on sram_q,
// which lengthens the tracking pipeline from 1 to 2 stages.
// ---------------------------------------------------------------------------
package ct_l2c_data_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 128;
    localparam int BE_W   = DATA_W / 8;

`ifdef CT_L2C_DATA_RD_FLOP_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // Expand one enable bit per byte into eight identical mask bits.
    function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < BE_W; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/ct_l2c_data_rsp_fifo.sv
// ---------------------------------------------------------------------------
// ct_l2c_data_rsp_fifo
// In-order synchronous FIFO holding returned read data. No bypass: a pushed
// entry becomes visible the cycle after the push.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   push_i/push_data_i write one entry
//   pop_i              consume the head entry
//   pop_data_o         head entry (undefined while empty)
//   full_o, empty_o    occupancy flags
//   count_o            occupancy, one bit wider than the pointers
// ---------------------------------------------------------------------------
module ct_l2c_data_rsp_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;

    // Pointers are exactly PW bits wide, so they wrap modulo DEPTH for free.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of process order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // observable after it has been written, and the count is what reset clears.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = (cnt_q == CW'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign count_o    = cnt_q;

endmodule

// File: rtl/ct_l2c_data_sram_ctrl.sv
// ---------------------------------------------------------------------------
// ct_l2c_data_sram_ctrl
// Access controller in front of the 2048x128 L2 data-array single-port SRAM.
// Accepts one read or write per cycle, drives the SRAM pins from flops, and
// returns read data in order through a credit-protected response FIFO.
// Ports:
//   forever_cpuclk, cpurst          clock, synchronous active-high reset
//   req_vld/req_rdy                 request handshake
//   req_wr/req_addr/req_wdata/req_wbe  request payload (1=write)
//   sram_a/cen/gwen/wen/d           registered SRAM pins (active-low enables)
//   sram_q                          SRAM read data
//   rsp_vld/rsp_rdy/rsp_data        in-order read response
// Build option: CT_L2C_DATA_RD_FLOP_EN registers sram_q before the FIFO
// (read latency 4 instead of 3). Credits cover both builds unchanged.
// ---------------------------------------------------------------------------
module ct_l2c_data_sram_ctrl
    import ct_l2c_data_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst,
    input  logic                    req_vld,
    output logic                    req_rdy,
    input  logic                    req_wr,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wbe,
    output logic [ADDR_WIDTH-1:0]   sram_a,
    output logic                    sram_cen,
    output logic                    sram_gwen,
    output logic [DATA_WIDTH-1:0]   sram_wen,
    output logic [DATA_WIDTH-1:0]   sram_d,
    input  logic [DATA_WIDTH-1:0]   sram_q,
    output logic                    rsp_vld,
    input  logic                    rsp_rdy,
    output logic [DATA_WIDTH-1:0]   rsp_data
);

    localparam int CW     = $clog2(RSP_DEPTH) + 1;
    localparam int PEND_W = CW + 1;

    // Pin stage
    logic                  cen_q,    cen_d;
    logic                  gwen_q,   gwen_d;
    logic [DATA_WIDTH-1:0] wen_q,    wen_d;
    logic [ADDR_WIDTH-1:0] a_q,      a_d;
    logic [DATA_WIDTH-1:0] dat_q,    dat_d;
    logic                  pin_rd_q, pin_rd_d;

    // Read tracking: trk_q[0] is high on the cycle sram_q is valid.
    logic [LAT-1:0]        trk_q;

    logic                  accept;
    logic                  rsp_pop;
    logic [PEND_W-1:0]     pending;
    logic [PEND_W-1:0]     pending_free;

    logic                  fifo_push;
    logic [DATA_WIDTH-1:0] fifo_wdata;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_cnt;

    // ------------------------------------------------------------------
    // Credits: every read from acceptance until it leaves the FIFO holds
    // one credit. Writes are also throttled so ordering stays trivial.
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        pending = PEND_W'(fifo_cnt) + PEND_W'(pin_rd_q);
        for (int i = 0; i < LAT; i++) begin
            pending = pending + PEND_W'(trk_q[i]);
        end
    end

    assign rsp_pop      = !fifo_empty && rsp_rdy;
    // A pop this cycle frees its slot in time for a same-cycle acceptance.
    assign pending_free = pending - PEND_W'(rsp_pop);
    assign req_rdy      = !cpurst && (pending_free < PEND_W'(RSP_DEPTH));
    assign accept       = req_vld && req_rdy;

    // ------------------------------------------------------------------
    // Pin stage next-state: without an acceptance only cen deasserts; the
    // remaining pins hold to avoid needless toggling on the macro inputs.
    // ------------------------------------------------------------------
    always_comb begin
        cen_d    = 1'b1;
        gwen_d   = gwen_q;
        wen_d    = wen_q;
        a_d      = a_q;
        dat_d    = dat_q;
        pin_rd_d = 1'b0;
        if (accept) begin
            cen_d    = 1'b0;
            a_d      = req_addr;
            pin_rd_d = !req_wr;
            if (req_wr) begin
                gwen_d = 1'b0;
                wen_d  = ~be_to_mask(req_wbe);
                dat_d  = req_wdata;
            end else begin
                gwen_d = 1'b1;
                wen_d  = '1;
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            cen_q    <= 1'b1;
            gwen_q   <= 1'b1;
            wen_q    <= '1;
            a_q      <= '0;
            dat_q    <= '0;
            pin_rd_q <= 1'b0;
        end else begin
            cen_q    <= cen_d;
            gwen_q   <= gwen_d;
            wen_q    <= wen_d;
            a_q      <= a_d;
            dat_q    <= dat_d;
            pin_rd_q <= pin_rd_d;
        end
    end

    // Reset clears the tracker, which is what drops reads in flight.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            trk_q <= '0;
        end else begin
            trk_q[0] <= pin_rd_q;
            for (int i = 1; i < LAT; i++) begin
                trk_q[i] <= trk_q[i-1];
            end
        end
    end

`ifdef CT_L2C_DATA_RD_FLOP_EN
    // Capture sram_q on its valid cycle; pushed one cycle later.
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            rd_data_q <= '0;
        end else if (trk_q[0]) begin
            rd_data_q <= sram_q;
        end
    end

    assign fifo_wdata = rd_data_q;
`else
    assign fifo_wdata = sram_q;
`endif

    assign fifo_push = trk_q[LAT-1];

    // The full gate is defensive only; credits make a push into a full
    // FIFO unreachable.
    ct_l2c_data_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk_i       (forever_cpuclk),
        .rst_i       (cpurst),
        .push_i      (fifo_push && !fifo_full),
        .push_data_i (fifo_wdata),
        .pop_i       (rsp_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_cnt)
    );

    assign sram_cen  = cen_q;
    assign sram_gwen = gwen_q;
    assign sram_wen  = wen_q;
    assign sram_a    = a_q;
    assign sram_d    = dat_q;

    assign rsp_vld   = !fifo_empty;
    // Masking keeps rsp_data at 0 after reset, when the array is stale.
    assign rsp_data  = fifo_empty ? '0 : fifo_head;

endmodule
